// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode constants, default sizes and selector-width helper
package mux_pkg;

  localparam logic MODE_RR     = 1'b0;
  localparam logic MODE_FORCED = 1'b1;

  localparam int DEF_N_CH   = 4;
  localparam int DEF_DATA_W = 2;
  localparam int DEF_SEL_W  = 2;

  // Smallest index width that can name every channel (never below 1 bit).
  function automatic int sel_w_for(input int n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int SEL_W = sel_w_for(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] index,
  output logic             any
);

  int cand;

  always_comb begin
    gnt   = '0;
    index = '0;
    any   = 1'b0;
    cand  = 0;
    // Scan last+1, last+2, ... with wrap; the first requester wins.
    for (int k = 1; k <= N_CH; k++) begin
      cand = (int'(last) + k) % N_CH;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        index     = SEL_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mux_rr_reg.sv
// rtl/mux_rr_reg.sv - N-channel registered mux, round-robin or forced select
// Optional parity_out output enabled by MUX_RR_PARITY_EN.
module mux_rr_reg
  import mux_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         selector,
  input  logic [N_CH-1:0]          valid_in,
  input  logic [N_CH*DATA_W-1:0]   data_in,
  output logic [N_CH-1:0]          pop,
  input  logic                     ready_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid_out,
  output logic [SEL_W-1:0]         grant_id
`ifdef MUX_RR_PARITY_EN
  ,
  output logic                     parity_out
`endif
);

  logic [SEL_W-1:0]  last;
  logic [N_CH-1:0]   rr_gnt;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_any;
  logic [N_CH-1:0]   forced_mask;
  logic [N_CH-1:0]   pick_gnt;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_any;
  logic [DATA_W-1:0] pick_data;
  logic              load_en;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req   (valid_in),
    .last  (last),
    .gnt   (rr_gnt),
    .index (rr_idx),
    .any   (rr_any)
  );

  // A selector beyond the last channel matches no bit, so nothing is eligible.
  always_comb begin
    forced_mask = '0;
    for (int i = 0; i < N_CH; i++) begin
      forced_mask[i] = (selector == SEL_W'(i));
    end
  end

  always_comb begin
    pick_gnt = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    if (mode == MODE_FORCED) begin
      pick_gnt = forced_mask & valid_in;
      pick_idx = selector;
      pick_any = |(forced_mask & valid_in);
    end else begin
      pick_gnt = rr_gnt;
      pick_idx = rr_idx;
      pick_any = rr_any;
    end
  end

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      pick_data = pick_data | (data_in[i*DATA_W +: DATA_W] & {DATA_W{pick_gnt[i]}});
    end
  end

  assign load_en = !valid_out || ready_in;
  assign pop     = (load_en && !reset) ? pick_gnt : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      grant_id  <= '0;
      last      <= SEL_W'(N_CH - 1);
    end else if (load_en) begin
      if (pick_any) begin
        data_out  <= pick_data;
        grant_id  <= pick_idx;
        valid_out <= 1'b1;
        // Forced grants leave the fairness pointer where round-robin left it.
        if (mode == MODE_RR) begin
          last <= pick_idx;
        end
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

`ifdef MUX_RR_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_out <= 1'b0;
    end else if (load_en && pick_any) begin
      parity_out <= ^pick_data;
    end
  end
`endif

endmodule

// File: tb/tb_mux_rr_reg.sv
// tb/tb_mux_rr_reg.sv - randomized and directed bench against a behavioural model
module tb_mux_rr_reg;

  localparam int N_CH   = 4;
  localparam int DATA_W = 2;
  localparam int SEL_W  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode;
  logic [1:0] selector;
  logic [3:0] valid_in;
  logic [7:0] data_in;
  logic [3:0] pop;
  logic       ready_in;
  logic [1:0] data_out;
  logic       valid_out;
  logic [1:0] grant_id;

  logic       mode3;
  logic [1:0] sel3;
  logic [2:0] valid_in3;
  logic [5:0] data_in3;
  logic [2:0] pop3;
  logic [1:0] data_out3;
  logic       valid_out3;
  logic [1:0] grant_id3;

`ifdef MUX_RR_PARITY_EN
  logic parity_out;
  logic parity_out3;
`endif

  mux_rr_reg #(.N_CH(N_CH), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .selector  (selector),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .pop       (pop),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .grant_id  (grant_id)
`ifdef MUX_RR_PARITY_EN
    ,
    .parity_out(parity_out)
`endif
  );

  mux_rr_reg #(.N_CH(3), .DATA_W(2), .SEL_W(2)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode3),
    .selector  (sel3),
    .valid_in  (valid_in3),
    .data_in   (data_in3),
    .pop       (pop3),
    .ready_in  (ready_in),
    .data_out  (data_out3),
    .valid_out (valid_out3),
    .grant_id  (grant_id3)
`ifdef MUX_RR_PARITY_EN
    ,
    .parity_out(parity_out3)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int       m_last;
  bit       m_valid;
  bit [1:0] m_data;
  int       m_gid;
  bit       m_par;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Spec rule: forced picks selector if in range and valid; RR scans last+1.. with wrap.
  function automatic int model_pick(input bit m, input int sel, input logic [3:0] v, input int last);
    if (m) return (sel < N_CH && v[sel]) ? sel : -1;
    for (int k = 1; k <= N_CH; k++) begin
      if (v[(last + k) % N_CH]) return (last + k) % N_CH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last  = N_CH - 1;
    m_valid = 1'b0;
    m_data  = 2'd0;
    m_gid   = 0;
    m_par   = 1'b0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_valid"}, valid_out, m_valid);
    chk({tag, "_data"}, data_out, m_data);
    chk({tag, "_gid"}, grant_id, m_gid);
`ifdef MUX_RR_PARITY_EN
    chk({tag, "_par"}, parity_out, m_par);
`endif
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit m, input logic [1:0] sel, input logic [3:0] v,
                      input logic [7:0] d, input bit rdy);
    int         p;
    bit         ld;
    logic [3:0] exp_pop;
    mode = m; selector = sel; valid_in = v; data_in = d; ready_in = rdy;
    #1;
    ld = !m_valid || rdy;
    p  = model_pick(m, int'(sel), v, m_last);
    exp_pop = (ld && p >= 0) ? 4'(1 << p) : 4'b0;
    chk("pop", pop, exp_pop);
    @(posedge clk);
    if (ld) begin
      if (p >= 0) begin
        m_data  = d[p*2 +: 2];
        m_gid   = p;
        m_valid = 1'b1;
        m_par   = ^d[p*2 +: 2];
        if (!m) m_last = p;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check_outs("out");
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int exp_seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1; mode = 1'b0; selector = 2'd0; valid_in = 4'b0; data_in = 8'h0; ready_in = 1'b1;
    mode3 = 1'b1; sel3 = 2'd3; valid_in3 = 3'b111; data_in3 = 6'h3f;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs("rst");
    chk("rst_pop", pop, 4'b0);
    reset = 1'b0;

    // Round-robin fairness from reset.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'd0, 4'b1111, 8'he4, 1'b1);
      chk("rr_seq", grant_id, exp_seq[i]);
    end
    // Sparse wrap after grant to 0.
    step(1'b0, 2'd0, 4'b1001, 8'he4, 1'b1);
    chk("sparse_3", grant_id, 3);
    step(1'b0, 2'd0, 4'b1001, 8'he4, 1'b1);
    chk("sparse_0", grant_id, 0);

    // Forced mode.
    step(1'b1, 2'd2, 4'b0100, 8'h20, 1'b1);
    chk("forced_d", data_out, 2'd2);
    step(1'b1, 2'd2, 4'b0100, 8'h10, 1'b1);
    chk("forced_d2", data_out, 2'd1);
    step(1'b1, 2'd2, 4'b1011, 8'hff, 1'b1);
    chk("forced_idle", valid_out, 1'b0);
    step(1'b1, 2'd3, 4'b1111, 8'h9c, 1'b1);
    chk("forced_3", grant_id, 3);

    // Three-channel instance: selector 3 is out of range and never grants.
    for (int i = 0; i < 3; i++) begin
      chk("n3_valid", valid_out3, 1'b0);
      chk("n3_pop", pop3, 3'b0);
      @(negedge clk);
    end

    // Backpressure then drain-and-refill.
    step(1'b0, 2'd0, 4'b1111, 8'he4, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 4'b1111, 8'(i * 37), 1'b0);
    step(1'b0, 2'd0, 4'b1111, 8'he4, 1'b1);
    chk("refill_valid", valid_out, 1'b1);

    // Mode switch keeps the round-robin pointer.
    do_reset();
    step(1'b0, 2'd0, 4'b0010, 8'he4, 1'b1);
    chk("ms_g1", grant_id, 1);
    step(1'b1, 2'd3, 4'b1111, 8'he4, 1'b1);
    step(1'b1, 2'd3, 4'b1111, 8'he4, 1'b1);
    step(1'b0, 2'd0, 4'b1111, 8'he4, 1'b1);
    chk("ms_resume", grant_id, 2);
`ifdef MUX_RR_PARITY_EN
    step(1'b1, 2'd1, 4'b0010, 8'h04, 1'b1);
    chk("parity_01", parity_out, 1'b1);
`endif

    // Asynchronous reset mid-cycle while holding a word.
    step(1'b0, 2'd0, 4'b1111, 8'he6, 1'b0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outs("arst");
    chk("arst_pop", pop, 4'b0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 2'd0, 4'b0001, 8'he6, 1'b1);
    chk("rel_data", data_out, 2'd2);
    chk("rel_gid", grant_id, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) == 0, 2'($urandom), 4'($urandom), 8'($urandom), ($urandom % 4) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
